// File: rtl/mcp_bus_sync_rx.sv
// rtl/mcp_bus_sync_rx.sv - destination-side controller of a multi-cycle-path bus synchronizer
//
// Purpose:
//   Consumes a request toggle that has already passed through a two-flop
//   synchronizer. It captures the quasi-static source bus and presents the
//   word on a valid/ready interface. It returns an acknowledge toggle to the
//   source domain, and flags requests that arrive while a word is still held.
//
// Ports:
//   clk          destination-domain clock
//   rst          asynchronous active-low reset, clears all state
//   req_sync     request toggle level, already synchronized into clk
//   bus_in       source bus, quasi-static while a request is outstanding
//   out_ready    downstream ready
//   overrun_clr  synchronous clear of the sticky overrun flag
//   out_data     captured word
//   out_valid    out_data holds an unconsumed word (HOLD state)
//   ack_tgl      acknowledge toggle level back to the source domain
//   overrun      sticky: request edge seen while a word was held
//   busy         high in HOLD state (same bit as out_valid)
module mcp_bus_sync_rx #(
  parameter int width    = 4,
  parameter bit ack_mode = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_sync,
  input  logic [width-1:0] bus_in,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  output logic             ack_tgl,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q;
  logic               req_q;
  logic [width-1:0]   data_q;
  logic               ack_q;
  logic               overrun_q;
  logic               req_edge;

  // Each toggle of the request level, of either polarity, is one request.
  assign req_edge = req_sync ^ req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // The edge is always consumed, even when the request is dropped.
      req_q <= req_sync;

      // Set has priority over clear, so no violation is lost.
      if (req_edge && (state_q == HOLD)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (req_edge) begin
            data_q  <= bus_in;
            state_q <= HOLD;
            if (ack_mode) begin
              ack_q <= ~ack_q;
            end
          end
        end
        HOLD: begin
          // An edge arriving here is dropped; a transfer in the same cycle
          // still completes normally.
          if (out_ready) begin
            state_q <= IDLE;
            if (!ack_mode) begin
              ack_q <= ~ack_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == HOLD);
  assign ack_tgl   = ack_q;
  assign overrun   = overrun_q;

endmodule
